// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// State and grant encodings are fixed so external checkers can decode them.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin grant: a lone requester wins, and on a tie the
// requester that was not granted last wins.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = i_req | d_req;
        if (i_req && d_req) begin
            grant_id = (last_grant == GNT_I) ? GNT_D : GNT_I;
        end else if (d_req) begin
            grant_id = GNT_D;
        end else begin
            grant_id = GNT_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-port memory between the fetch and data ports.
// Handshake: req is held until its one-cycle ack; requests are only sampled in IDLE.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  i_req_i,
    input  logic [ADDR_WIDTH-1:0] i_addr_i,
    output logic                  i_ack_o,
    output logic [DATA_WIDTH-1:0] i_data_o,
    input  logic                  d_req_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic                  d_we_i,
    input  logic [DATA_WIDTH-1:0] d_data_i,
    output logic                  d_ack_o,
    output logic [DATA_WIDTH-1:0] d_data_o,
    output logic                  m_en_o,
    output logic                  m_we_o,
    output logic [ADDR_WIDTH-1:0] m_addr_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    input  logic [DATA_WIDTH-1:0] m_data_i,
    output logic                  busy_o
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LATENCY - 1);

    arb_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic                  last_q;
    logic                  gnt_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] i_data_q;
    logic [DATA_WIDTH-1:0] d_data_q;
    logic                  grant_valid;
    logic                  grant_id;

    rr_arb2 u_rr_arb2 (
        .i_req       (i_req_i),
        .d_req       (d_req_i),
        .last_grant  (last_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        m_en_o  = 1'b0;
        i_ack_o = 1'b0;
        d_ack_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                m_en_o  = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                i_ack_o = (gnt_q == GNT_I);
                d_ack_o = (gnt_q == GNT_D);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Hold registers are the only source for the memory side once granted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            last_q   <= GNT_I;
            gnt_q    <= GNT_I;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            i_data_q <= '0;
            d_data_q <= '0;
        end else begin
            if (state_q == IDLE && grant_valid) begin
                gnt_q   <= grant_id;
                last_q  <= grant_id;
                addr_q  <= (grant_id == GNT_D) ? d_addr_i : i_addr_i;
                we_q    <= (grant_id == GNT_D) & d_we_i;
                wdata_q <= (grant_id == GNT_D) ? d_data_i : '0;
            end
            if (state_q == ACCESS) begin
                cnt_q <= LAT_M1;
            end else if (state_q == WAIT && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (state_q == WAIT && cnt_q == '0 && !we_q) begin
                if (gnt_q == GNT_D) begin
                    d_data_q <= m_data_i;
                end else begin
                    i_data_q <= m_data_i;
                end
            end
        end
    end

    assign m_we_o   = m_en_o & we_q;
    assign m_addr_o = addr_q;
    assign m_data_o = wdata_q;
    assign i_data_o = i_data_q;
    assign d_data_o = d_data_q;
    assign busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (latency 1 and 4) driven side by side and
// checked every cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;

  logic        i_req[2], d_req[2], d_we[2];
  logic [31:0] i_addr[2], d_addr[2], d_wdata[2], m_rdata[2];
  logic        i_ack[2], d_ack[2], m_en[2], m_we[2], busy[2];
  logic [31:0] i_rdata[2], d_rdata[2], m_addr[2], m_wdata[2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit checking = 0;
  bit track = 0;

  // model: phase 0 = idle, 1 = strobe cycle, 2..L+1 = waiting, L+2 = ack cycle
  int          ph[2];
  logic        last_g[2], gnt[2], h_we[2];
  logic [31:0] h_addr[2], h_wd[2], e_idata[2], e_ddata[2];
  int          due[2];
  logic [31:0] due_addr[2];
  logic [0:0]  exp_q[$];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) dut_l1 (
    .clk_i(clk), .rst_i(rst),
    .i_req_i(i_req[0]), .i_addr_i(i_addr[0]), .i_ack_o(i_ack[0]), .i_data_o(i_rdata[0]),
    .d_req_i(d_req[0]), .d_addr_i(d_addr[0]), .d_we_i(d_we[0]), .d_data_i(d_wdata[0]),
    .d_ack_o(d_ack[0]), .d_data_o(d_rdata[0]),
    .m_en_o(m_en[0]), .m_we_o(m_we[0]), .m_addr_o(m_addr[0]), .m_data_o(m_wdata[0]),
    .m_data_i(m_rdata[0]), .busy_o(busy[0])
  );

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(4)) dut_l4 (
    .clk_i(clk), .rst_i(rst),
    .i_req_i(i_req[1]), .i_addr_i(i_addr[1]), .i_ack_o(i_ack[1]), .i_data_o(i_rdata[1]),
    .d_req_i(d_req[1]), .d_addr_i(d_addr[1]), .d_we_i(d_we[1]), .d_data_i(d_wdata[1]),
    .d_ack_o(d_ack[1]), .d_data_o(d_rdata[1]),
    .m_en_o(m_en[1]), .m_we_o(m_we[1]), .m_addr_o(m_addr[1]), .m_data_o(m_wdata[1]),
    .m_data_i(m_rdata[1]), .busy_o(busy[1])
  );

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0F0F1234;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      int l;
      l = lat(k);
      if (rst) begin
        ph[k] = 0; last_g[k] = 1'b0; gnt[k] = 1'b0; h_we[k] = 1'b0;
        h_addr[k] = '0; h_wd[k] = '0; e_idata[k] = '0; e_ddata[k] = '0;
      end else if (ph[k] == 0) begin
        if (i_req[k] || d_req[k]) begin
          // fair choice: lone requester wins, a tie goes to whoever waited
          gnt[k] = (i_req[k] && d_req[k]) ? ~last_g[k] : d_req[k];
          last_g[k] = gnt[k];
          h_addr[k] = gnt[k] ? d_addr[k] : i_addr[k];
          h_we[k] = gnt[k] & d_we[k];
          h_wd[k] = gnt[k] ? d_wdata[k] : 32'h0;
          ph[k] = 1;
        end
      end else if (ph[k] == l + 2) begin
        ph[k] = 0;
      end else begin
        if (ph[k] == l + 1 && !h_we[k]) begin
          if (gnt[k]) e_ddata[k] = mem_word(h_addr[k]);
          else e_idata[k] = mem_word(h_addr[k]);
        end
        ph[k]++;
      end
    end
  endtask

  task automatic compare();
    for (int k = 0; k < 2; k++) begin
      int l, p;
      l = lat(k);
      p = ph[k];
      check($sformatf("busy%0d", k), 32'(busy[k]), 32'(p != 0));
      check($sformatf("m_en%0d", k), 32'(m_en[k]), 32'(p == 1));
      check($sformatf("m_we%0d", k), 32'(m_we[k]), 32'(p == 1 && h_we[k]));
      check($sformatf("i_ack%0d", k), 32'(i_ack[k]), 32'(p == l + 2 && gnt[k] == 1'b0));
      check($sformatf("d_ack%0d", k), 32'(d_ack[k]), 32'(p == l + 2 && gnt[k] == 1'b1));
      check($sformatf("m_addr%0d", k), m_addr[k], h_addr[k]);
      check($sformatf("m_wdata%0d", k), m_wdata[k], h_wd[k]);
      check($sformatf("i_data%0d", k), i_rdata[k], e_idata[k]);
      check($sformatf("d_data%0d", k), d_rdata[k], e_ddata[k]);
    end
    if (track && (i_ack[0] === 1'b1 || d_ack[0] === 1'b1)) begin
      if (exp_q.size() == 0) begin
        check("ack_order_extra", 32'd1, 32'd0);
      end else begin
        logic [0:0] e;
        e = exp_q.pop_front();
        check("ack_order", 32'(d_ack[0]), 32'(e));
      end
    end
  endtask

  // memory returns the word only in the cycle exactly MEM_LATENCY after the strobe
  task automatic mem_update();
    for (int k = 0; k < 2; k++) begin
      if (m_en[k] === 1'b1) begin
        due[k] = cyc + lat(k);
        due_addr[k] = m_addr[k];
      end
      m_rdata[k] = (cyc == due[k]) ? mem_word(due_addr[k]) : $urandom;
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
    cyc++;
    if (checking) compare();
    mem_update();
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while ((i_req[0] || d_req[0] || i_req[1] || d_req[1] || ph[0] != 0 || ph[1] != 0) && n < max) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        if (i_ack[k] === 1'b1) i_req[k] = 1'b0;
        if (d_ack[k] === 1'b1) d_req[k] = 1'b0;
      end
      n++;
    end
    check("drain_timeout", 32'(i_req[0] | d_req[0] | i_req[1] | d_req[1]), 32'd0);
  endtask

  task automatic set_both(input logic ir, input logic [31:0] ia, input logic dr,
                          input logic dw, input logic [31:0] da, input logic [31:0] dd);
    for (int k = 0; k < 2; k++) begin
      i_req[k] = ir; i_addr[k] = ia;
      d_req[k] = dr; d_we[k] = dw; d_addr[k] = da; d_wdata[k] = dd;
    end
  endtask

  task automatic rand_drive();
    for (int k = 0; k < 2; k++) begin
      if (!(i_req[k] && i_ack[k] !== 1'b1)) i_req[k] = ($urandom_range(0, 2) == 0);
      if (!(d_req[k] && d_ack[k] !== 1'b1)) d_req[k] = ($urandom_range(0, 2) == 0);
      i_addr[k] = $urandom;
      d_addr[k] = $urandom;
      d_wdata[k] = $urandom;
      d_we[k] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic reset_cycle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_both(1'b0, '0, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 2; k++) begin
      m_rdata[k] = '0; due[k] = -1; due_addr[k] = '0; ph[k] = 0;
    end
    tick();
    checking = 1;
    reset_cycle();

    // conflict straight after reset: data first, then strict alternation
    set_both(1'b1, 32'h100, 1'b1, 1'b0, 32'h40, 32'h0);
    exp_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    track = 1;
    for (int n = 0; n < 24; n++) tick();
    track = 0;
    check("ack_order_left", 32'(exp_q.size()), 32'd0);
    set_both(1'b0, '0, 1'b0, 1'b0, '0, '0);
    drain(20);

    // single fetch and a data write
    set_both(1'b1, 32'h100, 1'b0, 1'b0, '0, '0);
    drain(20);
    set_both(1'b0, '0, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF);
    drain(20);

    // read whose port-side address changes while the access is in flight
    set_both(1'b0, '0, 1'b1, 1'b0, 32'h40, 32'h0);
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      d_addr[k] = 32'h999;
      d_wdata[k] = $urandom;
    end
    drain(20);

    // reset while both instances sit in WAIT, then a fresh conflict
    set_both(1'b0, '0, 1'b1, 1'b0, 32'h40, 32'h0);
    tick();
    tick();
    d_req[0] = 1'b0;
    d_req[1] = 1'b0;
    reset_cycle();
    for (int n = 0; n < 6; n++) tick();
    set_both(1'b1, 32'h300, 1'b1, 1'b0, 32'h44, 32'h0);
    exp_q = '{1'b1, 1'b0};
    track = 1;
    for (int n = 0; n < 8; n++) tick();
    track = 0;
    check("ack_order_after_reset", 32'(exp_q.size()), 32'd0);
    set_both(1'b0, '0, 1'b0, 1'b0, '0, '0);
    drain(20);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rand_drive();
      tick();
    end
    set_both(1'b0, '0, 1'b0, 1'b0, '0, '0);
    drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
